// File: rtl/mc_ctrl_fsm_pkg.sv
// mc_ctrl_fsm_pkg: shared state, instruction-class, select and opcode encodings for the multi-cycle controller
package mc_ctrl_fsm_pkg;
  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;
  typedef enum logic [3:0] {
    C_R, C_LW, C_SW, C_BEQ, C_BNE, C_IMM, C_J, C_JAL, C_JR, C_ILL
  } cls_t;
  localparam logic [1:0] NPC_PC4 = 2'b00, NPC_BR = 2'b01, NPC_J = 2'b10, NPC_JR = 2'b11;
  localparam logic [1:0] WD_ALU = 2'b00, WD_MDR = 2'b01, WD_PC4 = 2'b10;
  localparam logic [1:0] GPR_RD = 2'b00, GPR_RT = 2'b01, GPR_RA = 2'b10;
  localparam logic [3:0] ALU_NOP = 4'd0, ALU_ADD = 4'd1, ALU_SUB = 4'd2, ALU_AND = 4'd3,
                         ALU_OR = 4'd4, ALU_SLT = 4'd5, ALU_SLL = 4'd6, ALU_LUI = 4'd7;
  localparam logic [5:0] OP_R = 6'h00, OP_J = 6'h02, OP_JAL = 6'h03, OP_BEQ = 6'h04,
                         OP_BNE = 6'h05, OP_ADDI = 6'h08, OP_ORI = 6'h0D, OP_LUI = 6'h0F,
                         OP_LW = 6'h23, OP_SW = 6'h2B;
  localparam logic [5:0] FN_SLL = 6'h00, FN_JR = 6'h08, FN_ADD = 6'h20, FN_SUB = 6'h22,
                         FN_AND = 6'h24, FN_OR = 6'h25, FN_SLT = 6'h2A;
endpackage

// File: rtl/mc_ctrl_decode.sv
// mc_ctrl_decode: combinational op/funct decode into instruction class and ALU controls
module mc_ctrl_decode
  import mc_ctrl_fsm_pkg::*;
(
  input  logic [5:0] op,
  input  logic [5:0] funct,
  output cls_t       cls,
  output logic [3:0] alu_op,
  output logic       ext_op,
  output logic       alu_src
);
  always_comb begin
    cls = C_ILL;
    alu_op = ALU_NOP;
    ext_op = 1'b1;
    alu_src = 1'b0;
    case (op)
      OP_R: begin
        cls = C_R;
        case (funct)
          FN_ADD: alu_op = ALU_ADD;
          FN_SUB: alu_op = ALU_SUB;
          FN_AND: alu_op = ALU_AND;
          FN_OR:  alu_op = ALU_OR;
          FN_SLT: alu_op = ALU_SLT;
          FN_SLL: alu_op = ALU_SLL;
          FN_JR:  cls = C_JR;
          default: cls = C_ILL;
        endcase
      end
      OP_LW: begin
        cls = C_LW;
        alu_op = ALU_ADD;
        alu_src = 1'b1;
      end
      OP_SW: begin
        cls = C_SW;
        alu_op = ALU_ADD;
        alu_src = 1'b1;
      end
      OP_BEQ: begin
        cls = C_BEQ;
        alu_op = ALU_SUB;
      end
      OP_BNE: begin
        cls = C_BNE;
        alu_op = ALU_SUB;
      end
      OP_ADDI: begin
        cls = C_IMM;
        alu_op = ALU_ADD;
        alu_src = 1'b1;
      end
      OP_ORI: begin
        cls = C_IMM;
        alu_op = ALU_OR;
        alu_src = 1'b1;
        ext_op = 1'b0;
      end
      OP_LUI: begin
        cls = C_IMM;
        alu_op = ALU_LUI;
        alu_src = 1'b1;
        ext_op = 1'b0;
      end
      OP_J:   cls = C_J;
      OP_JAL: cls = C_JAL;
      default: cls = C_ILL;
    endcase
  end
endmodule

// File: rtl/mc_ctrl_fsm.sv
// mc_ctrl_fsm: multi-cycle MIPS control FSM with memory-ready handshake and bus timeout
module mc_ctrl_fsm
  import mc_ctrl_fsm_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_rdy,
  output logic       PCWr,
  output logic [1:0] NPCOp,
  output logic       IRWr,
  output logic       MemRd,
  output logic       MemWr,
  output logic       IorD,
  output logic       RegWr,
  output logic [1:0] GPRSel,
  output logic [1:0] WDSel,
  output logic       ALUSrc,
  output logic       EXTOp,
  output logic [3:0] ALUOp,
  output logic       illegal,
  output logic       bus_err,
  output logic [2:0] state
);
  localparam int CW = MEM_TIMEOUT > 1 ? $clog2(MEM_TIMEOUT) : 1;
  state_t st;
  cls_t cls;
  logic [3:0] dec_alu;
  logic dec_ext, dec_src;
  logic [CW-1:0] cnt;
  logic waiting, expire;
  logic in_f, in_d, in_e, in_m, in_w, d_jmp, jal_wr, alu_hold;
  mc_ctrl_decode u_dec (
    .op(op),
    .funct(funct),
    .cls(cls),
    .alu_op(dec_alu),
    .ext_op(dec_ext),
    .alu_src(dec_src)
  );
  assign waiting = (st == S_FETCH || st == S_MEM) && !mem_rdy;
  assign expire = waiting && (MEM_TIMEOUT != 0) && cnt == CW'(MEM_TIMEOUT - 1);
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st <= S_FETCH;
      cnt <= '0;
      bus_err <= 1'b0;
    end else begin
      cnt <= waiting ? cnt + 1'b1 : '0;
      if (expire) begin
        bus_err <= 1'b1;
        st <= S_HALT;
      end else begin
        case (st)
          S_FETCH:  st <= mem_rdy ? S_DECODE : S_FETCH;
          S_DECODE: st <= (cls inside {C_J, C_JAL, C_JR, C_ILL}) ? S_FETCH : S_EXEC;
          S_EXEC:   st <= (cls inside {C_BEQ, C_BNE}) ? S_FETCH :
                          (cls inside {C_LW, C_SW}) ? S_MEM : S_WB;
          S_MEM:    st <= !mem_rdy ? S_MEM : cls == C_LW ? S_WB : S_FETCH;
          S_WB:     st <= S_FETCH;
          S_HALT:   st <= S_HALT;
          default:  st <= S_FETCH;
        endcase
      end
    end
  end
  // Decode is gated by rst so every enable drops the instant reset asserts.
  assign in_f = rst && st == S_FETCH;
  assign in_d = rst && st == S_DECODE;
  assign in_e = rst && st == S_EXEC;
  assign in_m = rst && st == S_MEM;
  assign in_w = rst && st == S_WB;
  assign d_jmp = in_d && (cls inside {C_J, C_JAL});
  assign jal_wr = in_d && cls == C_JAL;
  assign alu_hold = in_e || in_m || in_w;
  assign PCWr = (in_f && mem_rdy) || d_jmp || (in_d && cls == C_JR) ||
                (in_e && ((cls == C_BEQ && zero) || (cls == C_BNE && !zero)));
  assign NPCOp = (in_d && cls == C_JR) ? NPC_JR : d_jmp ? NPC_J :
                 (in_e && (cls inside {C_BEQ, C_BNE})) ? NPC_BR : NPC_PC4;
  assign IRWr = in_f && mem_rdy;
  assign MemRd = in_f || (in_m && cls == C_LW);
  assign MemWr = in_m && cls == C_SW;
  assign IorD = in_m;
  assign RegWr = in_w || jal_wr;
  assign GPRSel = jal_wr ? GPR_RA : (in_w && cls != C_R) ? GPR_RT : GPR_RD;
  assign WDSel = jal_wr ? WD_PC4 : (in_w && cls == C_LW) ? WD_MDR : WD_ALU;
  assign ALUOp = alu_hold ? dec_alu : ALU_NOP;
  assign ALUSrc = alu_hold && dec_src;
  assign EXTOp = alu_hold && dec_ext;
  assign illegal = in_d && cls == C_ILL;
  assign state = st;
endmodule

// File: doc/mc_ctrl_fsm.md
Name: mc_ctrl_fsm

Overview:
- Multi-cycle control unit that sequences the PC register, instruction register, register file, ALU and data memory.
- Decodes the MIPS opcode/funct latched in IR and steps through FETCH/DECODE/EXEC/MEM/WB.
- Drives PCWr (the PC register's write enable) and the NPC select on exactly the cycles a PC update is legal.
- Waits on a memory-ready handshake so variable-latency instruction/data memory can be used.

Parameters:
- MEM_TIMEOUT, 16, max cycles waiting for mem_rdy before flagging bus_err (0 disables the timeout).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- op  in  6  IR[31:26].
- funct  in  6  IR[5:0].
- zero  in  1  ALU zero flag from the EXEC cycle.
- mem_rdy  in  1  memory access complete this cycle.
- PCWr  out  1  PC write enable.
- NPCOp  out  2  NPC select: 00 PC+4, 01 branch, 10 jump, 11 jr.
- IRWr  out  1  IR load.
- MemRd  out  1  memory read request.
- MemWr  out  1  memory write request.
- IorD  out  1  0 = instruction address, 1 = data address.
- RegWr  out  1  register file write.
- GPRSel  out  2  dest: 00 rd, 01 rt, 10 $31.
- WDSel  out  2  write data: 00 ALU, 01 MDR, 10 PC+4.
- ALUSrc  out  1  0 = rt, 1 = immediate.
- EXTOp  out  1  1 = sign extend, 0 = zero extend.
- ALUOp  out  4  ALU function code.
- illegal  out  1  one-cycle pulse on an unsupported op/funct.
- bus_err  out  1  sticky flag; cleared by reset.
- state  out  3  current state, for debug.

Behaviour:
- Reset (rst low, asynchronous): state=FETCH, pending_first=1. All enables (PCWr, IRWr, MemRd, MemWr, RegWr) are 0, every select is 0, illegal=0, bus_err=0.
- The first FETCH after reset release issues MemRd at PC, which the PC register has loaded with TEXT_BASE_ADDRESS.
- State set: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5. Values 6 and 7 are unreachable and recover to FETCH.
- All outputs are Moore outputs decoded from state plus the latched op/funct/zero. The one exception is mem_rdy gating in FETCH/MEM, which is a Mealy term.
- FETCH: MemRd=1, IorD=0. While mem_rdy=0, hold FETCH with no writes. On the cycle mem_rdy=1, assert IRWr=1, PCWr=1, NPCOp=00 and go to DECODE.
- DECODE:
  - j: PCWr=1, NPCOp=10, then FETCH.
  - jal: PCWr=1, NPCOp=10, RegWr=1, GPRSel=10, WDSel=10 in the same cycle, then FETCH.
  - jr (op 0, funct 0x08): PCWr=1, NPCOp=11, then FETCH.
  - Supported ops (R add/sub/and/or/slt/sll, lw 0x23, sw 0x2B, beq 0x04, bne 0x05, addi 0x08, ori 0x0D, lui 0x0F) go to EXEC.
  - Anything else: illegal=1 for one cycle, then FETCH. The PC has already advanced by 4, so the instruction is skipped.
- EXEC:
  - beq: PCWr=zero, NPCOp=01, then FETCH.
  - bne: PCWr=~zero, NPCOp=01, then FETCH.
  - lw/sw: ALUSrc=1, EXTOp=1, ALU add, then MEM.
  - Other supported ops: then WB.
- MEM: IorD=1, MemRd=1 (lw) or MemWr=1 (sw). Hold until mem_rdy. On mem_rdy: sw goes to FETCH, lw goes to WB. MemWr must stay asserted every waiting cycle.
- WB: RegWr=1. R-type uses GPRSel=00, WDSel=00. I-type uses GPRSel=01. lw uses WDSel=01. Then FETCH.
- ALUOp/ALUSrc/EXTOp: held stable from EXEC through WB for the decoded instruction. ori and lui use EXTOp=0.
- Timeout: counter cleared on entry to FETCH/MEM, increments per waiting cycle. On reaching MEM_TIMEOUT, set bus_err and go to HALT.
- HALT: all enables 0. Exit only via reset.
- PCWr is never asserted in MEM, WB or HALT, nor while waiting for mem_rdy.
- Reset asserted mid-instruction: any pending write is dropped and the FSM returns to FETCH asynchronously.
- CPI: R/I-type 4, lw 5, sw 4, branch 3, jump 2 (plus memory wait cycles).

Decomposition:
- State codes, NPCOp/WDSel/GPRSel/ALUOp encodings and opcode/funct constants are added to the shared ctrl_encode_def.v.
- One natural sub-module, mc_ctrl_decode: purely combinational op/funct → instruction class plus ALUOp/EXTOp/ALUSrc.
- The FSM, wait counter and output decode stay in mc_ctrl_fsm.

Test Plan:
- Reset then mem_rdy=1 always, IR=add $3,$1,$2 (0x00221820): states 0,1,2,4,0; PCWr high only in cycle 1; RegWr=1, GPRSel=00 in WB.
- lw 0x8C220004 with mem_rdy low for 3 MEM cycles: MemRd and IorD=1 held 4 cycles; WB has WDSel=01; total 8 cycles.
- beq with zero=1, then with zero=0: EXEC PCWr=1, NPCOp=01 in the first case; PCWr=0 in the second; both return to FETCH.
- jal 0x0C000010: DECODE asserts PCWr=1, NPCOp=10, RegWr=1, GPRSel=10, WDSel=10; next state FETCH.
- op=0x3F: illegal pulses for 1 cycle, no RegWr/MemWr, next state FETCH. mem_rdy stuck low with MEM_TIMEOUT=16: bus_err=1 after 16 cycles, state=HALT.
- rst pulled low during MEM of sw: MemWr drops immediately, state=FETCH; after release, FETCH MemRd=1, IorD=0.
